decode_stage: RTL and testbench

- Registered, handshaked RV32I/RV64I instruction decode stage, parametrised in XLEN.
- Sits between fetch and execute. Accepts an instruction and PC, and emits a registered control bundle with fully sign-extended immediates per format.
- Adds over the combinational decoder: slt/sltu, LUI/AUIPC, illegal-instruction flag, 2-entry skid buffering, flush, and one-cycle load-use bubble insertion.

---
 rtl/decode_stage.sv | 257 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// decode_stage : registered RV32I/RV64I decode with skid buffer, flush and
//                load-use bubble insertion.
// Revision 1.0
// ============================================================================
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int HAZARD_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_op,
  output logic [1:0]      out_alu_src,
  output logic [1:0]      out_branch_sel,
  output logic            out_mr,
  output logic            out_mtr,
  output logic            out_mw,
  output logic            out_rw,
  output logic            out_illegal
);

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_f7_alt    = 7'b0100000;

  localparam logic [3:0] c_alu_add  = 4'd0;
  localparam logic [3:0] c_alu_sub  = 4'd1;
  localparam logic [3:0] c_alu_sll  = 4'd2;
  localparam logic [3:0] c_alu_slt  = 4'd3;
  localparam logic [3:0] c_alu_sltu = 4'd4;
  localparam logic [3:0] c_alu_xor  = 4'd5;
  localparam logic [3:0] c_alu_srl  = 4'd6;
  localparam logic [3:0] c_alu_sra  = 4'd7;
  localparam logic [3:0] c_alu_or   = 4'd8;
  localparam logic [3:0] c_alu_and  = 4'd9;

  typedef struct packed {
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic [1:0]      alu_src;
    logic [1:0]      bsel;
    logic            mr;
    logic            mtr;
    logic            mw;
    logic            rw;
    logic            illegal;
  } dec_t;

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? c_alu_sub : c_alu_add;
      3'b001:  op = c_alu_sll;
      3'b010:  op = c_alu_slt;
      3'b011:  op = c_alu_sltu;
      3'b100:  op = c_alu_xor;
      3'b101:  op = alt ? c_alu_sra : c_alu_srl;
      3'b110:  op = c_alu_or;
      default: op = c_alu_and;
    endcase
    return op;
  endfunction

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t        d;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [63:0] imm64;
    opc   = instr[6:0];
    f3    = instr[14:12];
    f7    = instr[31:25];
    imm64 = '0;
    d     = '0;
    d.rd  = instr[11:7];
    d.rs1 = instr[19:15];
    d.rs2 = instr[24:20];
    case (opc)
      c_op_r: begin
        d.rw      = 1'b1;
        d.alu_op  = alu_from_f3(f3, f7[5]);
        d.illegal = !((f7 == 7'b0) ||
                      ((f7 == c_f7_alt) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      c_op_imm: begin
        d.rw      = 1'b1;
        d.alu_src = 2'd1;
        imm64     = {{52{instr[31]}}, instr[31:20]};
        // funct7 only qualifies the shift encodings; addi never becomes sub
        d.alu_op  = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
        if (f3 == 3'b001)
          d.illegal = (f7 != 7'b0);
        else if (f3 == 3'b101)
          d.illegal = (f7 != 7'b0) && (f7 != c_f7_alt);
      end
      c_op_load: begin
        d.alu_src = 2'd1;
        d.mr      = 1'b1;
        d.mtr     = 1'b1;
        d.rw      = 1'b1;
        imm64     = {{52{instr[31]}}, instr[31:20]};
      end
      c_op_store: begin
        d.alu_src = 2'd1;
        d.mw      = 1'b1;
        imm64     = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      end
      c_op_branch: begin
        d.alu_op = c_alu_sub;
        d.bsel   = 2'd1;
        imm64    = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      c_op_jal: begin
        d.bsel = 2'd2;
        d.rw   = 1'b1;
        imm64  = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      c_op_jalr: begin
        d.bsel    = 2'd3;
        d.rw      = 1'b1;
        d.alu_src = 2'd1;
        imm64     = {{52{instr[31]}}, instr[31:20]};
      end
      c_op_lui: begin
        d.alu_src = 2'd3;
        d.rw      = 1'b1;
        imm64     = {{32{instr[31]}}, instr[31:12], 12'b0};
      end
      c_op_auipc: begin
        d.alu_src = 2'd2;
        d.rw      = 1'b1;
        imm64     = {{32{instr[31]}}, instr[31:12], 12'b0};
      end
      default: d.illegal = 1'b1;
    endcase
    d.imm = imm64[XLEN-1:0];
    if (d.illegal) begin
      d.mr      = 1'b0;
      d.mtr     = 1'b0;
      d.mw      = 1'b0;
      d.rw      = 1'b0;
      d.bsel    = 2'd0;
      d.alu_op  = c_alu_add;
      d.alu_src = 2'd0;
      d.imm     = '0;
    end
    return d;
  endfunction

  logic            r_out_valid;
  dec_t            r_out;
  logic [XLEN-1:0] r_out_pc;
  logic            r_skid_valid;
  logic [31:0]     r_skid_instr;
  logic [XLEN-1:0] r_skid_pc;

  logic [31:0]     w_cand_instr;
  logic [XLEN-1:0] w_cand_pc;
  logic            w_cand_valid;
  logic            w_can_load;
  logic            w_shadow;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_hazard;
  logic            w_load;
  dec_t            w_dec;

  assign w_cand_instr = r_skid_valid ? r_skid_instr : in_instr;
  assign w_cand_pc    = r_skid_valid ? r_skid_pc : in_pc;
  assign w_cand_valid = r_skid_valid || in_valid;
  assign w_can_load   = !r_out_valid || out_ready;
  assign w_dec        = decode(w_cand_instr);

  // A load leaving this edge enters execute; a dependent candidate must wait one cycle.
  assign w_shadow  = (HAZARD_EN != 0) && r_out_valid && out_ready && r_out.mr && (r_out.rd != 5'd0);
  assign w_use_rs1 = (w_cand_instr[6:0] == c_op_r)     || (w_cand_instr[6:0] == c_op_imm)   ||
                     (w_cand_instr[6:0] == c_op_load)  || (w_cand_instr[6:0] == c_op_store) ||
                     (w_cand_instr[6:0] == c_op_branch)|| (w_cand_instr[6:0] == c_op_jalr);
  assign w_use_rs2 = (w_cand_instr[6:0] == c_op_r)     || (w_cand_instr[6:0] == c_op_store) ||
                     (w_cand_instr[6:0] == c_op_branch);
  assign w_hazard  = w_shadow &&
                     ((w_use_rs1 && (w_cand_instr[19:15] == r_out.rd)) ||
                      (w_use_rs2 && (w_cand_instr[24:20] == r_out.rd)));
  assign w_load    = w_can_load && w_cand_valid && !w_hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out        <= '0;
      r_out_pc     <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out       <= w_dec;
        r_out_pc    <= w_cand_pc;
      end else if (w_can_load) begin
        r_out_valid <= 1'b0;
      end
      // in_ready is low while the skid is occupied, so a pop never races a push
      if (r_skid_valid) begin
        if (w_load)
          r_skid_valid <= 1'b0;
      end else if (in_valid && !w_load) begin
        r_skid_valid <= 1'b1;
        r_skid_instr <= in_instr;
        r_skid_pc    <= in_pc;
      end
    end
  end

  assign in_ready       = !r_skid_valid;
  assign out_valid      = r_out_valid;
  assign out_pc         = r_out_pc;
  assign out_rd         = r_out.rd;
  assign out_rs1        = r_out.rs1;
  assign out_rs2        = r_out.rs2;
  assign out_imm        = r_out.imm;
  assign out_alu_op     = r_out.alu_op;
  assign out_alu_src    = r_out.alu_src;
  assign out_branch_sel = r_out.bsel;
  assign out_mr         = r_out.mr;
  assign out_mtr        = r_out.mtr;
  assign out_mw         = r_out.mw;
  assign out_rw         = r_out.rw;
  assign out_illegal    = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// Directed bench for decode_stage (XLEN=64), hazard-enabled and hazard-disabled instances.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_mr, out_mtr, out_mw, out_rw, out_illegal;
  logic [63:0] out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [3:0]  out_alu_op;
  logic [1:0]  out_alu_src, out_branch_sel;

  logic        n_in_ready, n_out_valid, n_out_mr, n_out_mtr, n_out_mw, n_out_rw, n_out_illegal;
  logic [63:0] n_out_pc, n_out_imm;
  logic [4:0]  n_out_rd, n_out_rs1, n_out_rs2;
  logic [3:0]  n_out_alu_op;
  logic [1:0]  n_out_alu_src, n_out_branch_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64), .HAZARD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_alu_src(out_alu_src), .out_branch_sel(out_branch_sel),
    .out_mr(out_mr), .out_mtr(out_mtr), .out_mw(out_mw), .out_rw(out_rw),
    .out_illegal(out_illegal)
  );

  decode_stage #(.XLEN(64), .HAZARD_EN(0)) dut_nh (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
    .out_rd(n_out_rd), .out_rs1(n_out_rs1), .out_rs2(n_out_rs2), .out_imm(n_out_imm),
    .out_alu_op(n_out_alu_op), .out_alu_src(n_out_alu_src), .out_branch_sel(n_out_branch_sel),
    .out_mr(n_out_mr), .out_mtr(n_out_mtr), .out_mw(n_out_mw), .out_rw(n_out_rw),
    .out_illegal(n_out_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    // asynchronous reset asserted mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_imm",   out_imm,        64'd0);
    chk("rst_out_pc",    out_pc,         64'd0);
    chk("rst_out_rw",    64'(out_rw),    64'd0);
    #9 rst_n = 1'b1;
    cyc();

    // addi x1,x0,-1
    drive(32'hFFF0_0093, 64'h1000);
    cyc();
    chk("addi_valid", 64'(out_valid),   64'd1);
    chk("addi_imm",   out_imm,          64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_op",    64'(out_alu_op),  64'd0);
    chk("addi_src",   64'(out_alu_src), 64'd1);
    chk("addi_rw",    64'(out_rw),      64'd1);
    chk("addi_rd",    64'(out_rd),      64'd1);
    chk("addi_pc",    out_pc,           64'h1000);
    in_valid = 1'b0;
    cyc();
    chk("addi_drain", 64'(out_valid), 64'd0);

    // backpressure: three pushes with out_ready low
    out_ready = 1'b0;
    drive(32'h0050_0113, 64'h2000);
    cyc();
    chk("bp1_rd",       64'(out_rd),   64'd2);
    chk("bp1_in_ready", 64'(in_ready), 64'd1);
    drive(32'h0060_0193, 64'h2004);
    cyc();
    chk("bp2_in_ready", 64'(in_ready), 64'd0);
    chk("bp2_hold_rd",  64'(out_rd),   64'd2);
    drive(32'h0070_0213, 64'h2008);
    cyc();
    chk("bp3_in_ready", 64'(in_ready), 64'd0);
    chk("bp3_hold_pc",  out_pc,        64'h2000);
    chk("bp3_hold_imm", out_imm,       64'd5);
    out_ready = 1'b1;
    cyc();
    chk("bp_drain1_rd",  64'(out_rd),   64'd3);
    chk("bp_drain1_imm", out_imm,       64'd6);
    chk("bp_drain1_rdy", 64'(in_ready), 64'd1);
    cyc();
    chk("bp_drain2_rd",  64'(out_rd), 64'd4);
    chk("bp_drain2_pc",  out_pc,      64'h2008);
    in_valid = 1'b0;
    cyc();
    chk("bp_drain3_valid", 64'(out_valid), 64'd0);

    // load-use: lw x5,0(x1) ; add x6,x5,x2
    drive(32'h0000_A283, 64'h3000);
    cyc();
    chk("lu_lw_valid", 64'(out_valid), 64'd1);
    chk("lu_lw_mr",    64'(out_mr),    64'd1);
    chk("lu_lw_mtr",   64'(out_mtr),   64'd1);
    chk("lu_lw_rd",    64'(out_rd),    64'd5);
    chk("nh_lw_rd",    64'(n_out_rd),  64'd5);
    drive(32'h0022_8333, 64'h3004);
    cyc();
    chk("lu_bubble",   64'(out_valid),   64'd0);
    chk("nh_nobubble", 64'(n_out_valid), 64'd1);
    chk("nh_add_rd",   64'(n_out_rd),    64'd6);
    in_valid = 1'b0;
    cyc();
    chk("lu_add_valid", 64'(out_valid),   64'd1);
    chk("lu_add_rd",    64'(out_rd),      64'd6);
    chk("lu_add_pc",    out_pc,           64'h3004);
    chk("lu_add_rs2",   64'(out_rs2),     64'd2);
    chk("nh_after",     64'(n_out_valid), 64'd0);
    cyc();
    chk("lu_drain", 64'(out_valid), 64'd0);

    // load to x0 never stalls: lw x0,0(x1) ; add x6,x0,x2
    drive(32'h0000_A003, 64'h3100);
    cyc();
    chk("lu0_lw_valid", 64'(out_valid), 64'd1);
    drive(32'h0020_0333, 64'h3104);
    cyc();
    chk("lu0_add_valid", 64'(out_valid), 64'd1);
    chk("lu0_add_rd",    64'(out_rd),    64'd6);
    in_valid = 1'b0;
    cyc();
    chk("lu0_drain", 64'(out_valid), 64'd0);

    // immediate formats and ALU ops, streamed
    drive(32'hFE00_0EE3, 64'h4000);
    cyc();
    chk("beq_imm",  out_imm,             64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_bsel", 64'(out_branch_sel), 64'd1);
    chk("beq_op",   64'(out_alu_op),     64'd1);
    chk("beq_rw",   64'(out_rw),         64'd0);
    drive(32'h0010_00EF, 64'h4004);
    cyc();
    chk("jal_imm",  out_imm,             64'h800);
    chk("jal_bsel", 64'(out_branch_sel), 64'd2);
    chk("jal_rw",   64'(out_rw),         64'd1);
    drive(32'h8000_03B7, 64'h4008);
    cyc();
    chk("lui_imm", out_imm,           64'hFFFF_FFFF_8000_0000);
    chk("lui_src", 64'(out_alu_src),  64'd3);
    chk("lui_rd",  64'(out_rd),       64'd7);
    drive(32'h0020_A433, 64'h400C);
    cyc();
    chk("slt_op",  64'(out_alu_op),  64'd3);
    chk("slt_imm", out_imm,          64'd0);
    chk("slt_src", 64'(out_alu_src), 64'd0);
    drive(32'h4030_D493, 64'h4010);
    cyc();
    chk("srai_op",  64'(out_alu_op), 64'd7);
    chk("srai_imm", out_imm,         64'h403);
    chk("srai_ill", 64'(out_illegal),64'd0);

    // illegal encodings still transfer
    drive(32'h0000_0000, 64'h5000);
    cyc();
    chk("ill0_valid", 64'(out_valid),   64'd1);
    chk("ill0_flag",  64'(out_illegal), 64'd1);
    chk("ill0_rw",    64'(out_rw),      64'd0);
    chk("ill0_mw",    64'(out_mw),      64'd0);
    drive(32'h4020_F433, 64'h5004);
    cyc();
    chk("illr_flag", 64'(out_illegal), 64'd1);
    chk("illr_rw",   64'(out_rw),      64'd0);
    chk("illr_op",   64'(out_alu_op),  64'd0);
    in_valid = 1'b0;
    cyc();

    // flush with output and skid both full; flush-cycle input is dropped
    out_ready = 1'b0;
    drive(32'h0050_0113, 64'h6000);
    cyc();
    drive(32'h0060_0193, 64'h6004);
    cyc();
    chk("fl_full", 64'(in_ready), 64'd0);
    drive(32'h0070_0213, 64'h6008);
    flush = 1'b1;
    cyc();
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready",  64'(in_ready),  64'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("fl_dropped", 64'(out_valid), 64'd0);
    drive(32'h0070_0213, 64'h6100);
    cyc();
    chk("fl_resume_rd", 64'(out_rd), 64'd4);
    chk("fl_resume_pc", out_pc,      64'h6100);
    in_valid = 1'b0;

    // reset while full discards everything immediately
    out_ready = 1'b0;
    drive(32'h0050_0113, 64'h7000);
    cyc();
    drive(32'h0060_0193, 64'h7004);
    cyc();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_in_ready",  64'(in_ready),  64'd1);
    chk("rst2_out_rd",    64'(out_rd),    64'd0);
    #2 rst_n = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
